lockpick_host_driver: RTL and testbench

//  Host-side initiator for the lockpick game core; the opposite end of its byte interface.

---
 rtl/lockpick_host_driver.sv | 170 +++++++++++++++++
 tb/tb_lockpick_host_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lockpick_host_driver.sv
// Host-side initiator for the lockpick game core: start pulse, 32 key bytes out, 16 result bytes in.
// Optional watchdog on the response phase is enabled by defining LOCKPICK_HOST_TIMEOUT_EN.
module lockpick_host_driver #(
    parameter int MSG_BYTES = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go,
    input  logic [8*MSG_BYTES-1:0]   key_a,
    input  logic [8*MSG_BYTES-1:0]   key_b,
    output logic                     start,
    output logic                     input_enable,
    output logic [7:0]               input_data,
    input  logic                     output_valid,
    input  logic [7:0]               output_data,
    input  logic [1:0]               status,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               result,
    output logic [8*MSG_BYTES-1:0]   rx_msg,
    output logic                     msg_ok,
    output logic                     in_session,
    output logic                     timed_out
);

    localparam int MSG_W = 8 * MSG_BYTES;

    typedef enum logic [2:0] {IDLE, START, SEND, WAIT, RECV, DONE} state_t;

    state_t             state, next_state;
    logic [5:0]         idx;
    logic [4:0]         idx_next;
    logic [3:0]         rx_cnt;
    logic [MSG_W-1:0]   key_a_q, key_b_q;
    logic [2*MSG_W-1:0] keys_q;
    logic [MSG_W-1:0]   last_msg;
    logic               wd_hit;

    assign keys_q   = {key_b_q, key_a_q};
    assign idx_next = idx[4:0] + 5'd1;
    // Full message as it will look once the final byte lands, so msg_ok appears together with done
    assign last_msg = {output_data, rx_msg[MSG_W-9:0]};

    function automatic logic msg_match(input logic [1:0] res, input logic [MSG_W-1:0] msg);
        case (res)
            2'b01:   return msg == {(MSG_W/16){16'hBAD0}};
            2'b10:   return msg == {(MSG_W/16){16'hFACE}};
            2'b11:   return msg == {(MSG_W/16){16'hDEAD}};
            default: return 1'b0;
        endcase
    endfunction

`ifdef LOCKPICK_HOST_TIMEOUT_EN
    logic [10:0] wdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wdog <= '0;
        else if ((state == WAIT || state == RECV) && !output_valid)
            wdog <= wdog + 11'd1;
        else
            wdog <= '0;
    end

    assign wd_hit = (state == WAIT || state == RECV) && !output_valid &&
                    (wdog == 11'(TIMEOUT - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (go) next_state = in_session ? SEND : START;
            START: next_state = SEND;
            SEND:  if (idx == 6'd31) next_state = WAIT;
            WAIT:  if (output_valid) next_state = RECV;
                   else if (wd_hit) next_state = DONE;
            RECV:  if (output_valid && rx_cnt == 4'd15) next_state = DONE;
                   else if (wd_hit) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are loaded on the edge entering each state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_a_q      <= '0;
            key_b_q      <= '0;
            idx          <= '0;
            rx_cnt       <= '0;
            start        <= 1'b0;
            input_enable <= 1'b0;
            input_data   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            rx_msg       <= '0;
            msg_ok       <= 1'b0;
            in_session   <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        key_a_q   <= key_a;
                        key_b_q   <= key_b;
                        busy      <= 1'b1;
                        rx_msg    <= '0;
                        msg_ok    <= 1'b0;
                        timed_out <= 1'b0;
                        idx       <= '0;
                        rx_cnt    <= '0;
                        if (in_session) begin
                            input_enable <= 1'b1;
                            input_data   <= key_a[7:0];
                        end else begin
                            start <= 1'b1;
                        end
                    end
                end
                START: begin
                    start        <= 1'b0;
                    input_enable <= 1'b1;
                    input_data   <= key_a_q[7:0];
                end
                SEND: begin
                    if (idx == 6'd31) begin
                        input_enable <= 1'b0;
                        input_data   <= '0;
                    end else begin
                        idx        <= idx + 6'd1;
                        input_data <= keys_q[8*idx_next +: 8];
                    end
                end
                WAIT, RECV: begin
                    if (output_valid) begin
                        rx_msg[8*rx_cnt +: 8] <= output_data;
                        rx_cnt                <= rx_cnt + 4'd1;
                        if (state == WAIT)
                            result <= status;
                        if (state == RECV && rx_cnt == 4'd15) begin
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            msg_ok     <= msg_match(result, last_msg);
                            in_session <= (result == 2'b01);
                        end
                    end else if (wd_hit) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        result     <= 2'b00;
                        timed_out  <= 1'b1;
                        msg_ok     <= 1'b0;
                        in_session <= 1'b0;
                    end
                end
                DONE: done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lockpick_host_driver.sv
// Scoreboard bench for lockpick_host_driver with a behavioural game model driving the response side.
module tb_lockpick_host_driver;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         go;
    logic [127:0] key_a, key_b;
    logic         start, input_enable;
    logic [7:0]   input_data;
    logic         output_valid;
    logic [7:0]   output_data;
    logic [1:0]   status;
    logic         busy, done;
    logic [1:0]   result;
    logic [127:0] rx_msg;
    logic         msg_ok, in_session, timed_out;

    typedef struct packed {
        logic [1:0]   res;
        logic [127:0] msg;
        logic         ok;
        logic         sess;
        logic         to;
        logic [4:0]   nbytes;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_bytes[$];

    int n_checks = 0;
    int n_fails  = 0;
    int start_cnt, done_cnt, en_cnt, en_runs, idle_data_err, bytes_sent;
    logic prev_en = 1'b0;

    lockpick_host_driver dut (
        .clk(clk), .rst_n(rst_n), .go(go), .key_a(key_a), .key_b(key_b),
        .start(start), .input_enable(input_enable), .input_data(input_data),
        .output_valid(output_valid), .output_data(output_data), .status(status),
        .busy(busy), .done(done), .result(result), .rx_msg(rx_msg),
        .msg_ok(msg_ok), .in_session(in_session), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Monitor: pops expected key bytes on every enable cycle and an expected result on every done
    always @(negedge clk) begin
        if (rst_n) begin
            if (start) start_cnt++;
            if (input_enable) begin
                en_cnt++;
                if (!prev_en) en_runs++;
                if (exp_bytes.size() == 0) checkOutput("extra_byte", 1, 0);
                else checkOutput("input_data", input_data, exp_bytes.pop_front());
            end else if (input_data != 8'd0) begin
                idle_data_err++;
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) checkOutput("done_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("result", result, e.res);
                    checkOutput("rx_msg", rx_msg, e.msg);
                    checkOutput("msg_ok", msg_ok, e.ok);
                    checkOutput("in_session", in_session, e.sess);
                    checkOutput("timed_out", timed_out, e.to);
                    checkOutput("busy_at_done", busy, 0);
                    checkOutput("bytes_before_done", bytes_sent, e.nbytes);
                end
            end
        end
        prev_en = input_enable;
    end

    task automatic applyStimulus(input logic [127:0] ka, input logic [127:0] kb,
                                 input logic [1:0] st, input logic [127:0] msg, input bit to);
        exp_t e;
        for (int i = 0; i < 16; i++) exp_bytes.push_back(ka[8*i +: 8]);
        for (int i = 0; i < 16; i++) exp_bytes.push_back(kb[8*i +: 8]);
        if (to) begin
            e = '{res: 2'b00, msg: '0, ok: 1'b0, sess: 1'b0, to: 1'b1, nbytes: 5'd0};
        end else begin
            e.res    = st;
            e.msg    = msg;
            e.ok     = (st == 2'b01 && msg == {8{16'hBAD0}}) ||
                       (st == 2'b10 && msg == {8{16'hFACE}}) ||
                       (st == 2'b11 && msg == {8{16'hDEAD}});
            e.sess   = (st == 2'b01);
            e.to     = 1'b0;
            e.nbytes = 5'd16;
        end
        exp_q.push_back(e);
        start_cnt = 0; done_cnt = 0; en_cnt = 0; en_runs = 0; idle_data_err = 0; bytes_sent = 0;
        @(negedge clk);
        go = 1'b1; key_a = ka; key_b = kb;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic waitSendEnd();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (en_cnt == 32 && !input_enable) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) checkOutput("send_end_timeout", 0, 1);
    endtask

    task automatic driveResponse(input logic [1:0] st, input logic [127:0] msg, input int gap);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            output_valid = 1'b1; status = st; output_data = msg[8*k +: 8];
            bytes_sent++;
            @(negedge clk);
            if (gap > 0) begin
                output_valid = 1'b0; output_data = 8'hEE;
                repeat (gap) @(negedge clk);
            end
        end
        output_valid = 1'b0; output_data = 8'h00; status = 2'b00;
    endtask

    task automatic finishAttempt(input bit exp_start);
        for (int i = 0; i < 2000 && done_cnt == 0; i++) @(negedge clk);
        if (done_cnt == 0) checkOutput("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("start_pulses", start_cnt, exp_start);
        checkOutput("enable_cycles", en_cnt, 32);
        checkOutput("enable_runs", en_runs, 1);
        checkOutput("idle_data_zero", idle_data_err, 0);
        checkOutput("busy_after", busy, 0);
    endtask

    task automatic runAttempt(input logic [127:0] ka, input logic [127:0] kb, input logic [1:0] st,
                              input logic [127:0] msg, input int gap, input bit exp_start);
        applyStimulus(ka, kb, st, msg, 1'b0);
        checkOutput("start_first_cycle", start, exp_start);
        checkOutput("enable_first_cycle", input_enable, !exp_start);
        checkOutput("busy_during", busy, 1);
        waitSendEnd();
        driveResponse(st, msg, gap);
        finishAttempt(exp_start);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] rmsg;
        rst_n = 1'b0; go = 1'b0; key_a = '0; key_b = '0;
        output_valid = 1'b0; output_data = '0; status = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_enable", input_enable, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_rx_msg", rx_msg, 0);
        checkOutput("rst_in_session", in_session, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray response bytes while idle must be ignored
        output_valid = 1'b1; status = 2'b10; output_data = 8'h55;
        repeat (3) @(negedge clk);
        output_valid = 1'b0; status = 2'b00; output_data = 8'h00;
        @(negedge clk);
        checkOutput("idle_valid_busy", busy, 0);
        checkOutput("idle_valid_msg", rx_msg, 0);
        checkOutput("idle_valid_result", result, 0);

        runAttempt(rand128(), rand128(), 2'b10, {8{16'hFACE}}, 0, 1'b1);
        runAttempt(rand128(), rand128(), 2'b01, {8{16'hBAD0}}, 0, 1'b1);
        runAttempt(rand128(), rand128(), 2'b11, {8{16'hDEAD}}, 0, 1'b0);
        rmsg = rand128();
        runAttempt(rand128(), rand128(), 2'b10, rmsg, 1, 1'b1);
        runAttempt(rand128(), rand128(), 2'b01, {8{16'hBAD0}}, 2, 1'b1);
        runAttempt(rand128(), rand128(), 2'b00, {8{16'hFACE}}, 0, 1'b0);
        runAttempt('0, '0, 2'b01, {8{16'hBAD0}}, 0, 1'b1);

        // Reset in the middle of the key stream (byte index 10)
        applyStimulus(rand128(), rand128(), 2'b10, {8{16'hFACE}}, 1'b0);
        for (int i = 0; i < 100 && en_cnt < 11; i++) @(negedge clk);
        checkOutput("reset_point_idx", en_cnt, 11);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_enable", input_enable, 0);
        checkOutput("midrst_data", input_data, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_in_session", in_session, 0);
        exp_bytes.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("midrst_no_done", done_cnt, 0);
        runAttempt(rand128(), rand128(), 2'b10, {8{16'hFACE}}, 0, 1'b1);

`ifdef LOCKPICK_HOST_TIMEOUT_EN
        begin
            int wcycles = 0;
            applyStimulus(rand128(), rand128(), 2'b00, '0, 1'b1);
            waitSendEnd();
            while (!done && wcycles < 1100) begin
                @(negedge clk);
                wcycles++;
            end
            checkOutput("watchdog_cycles", wcycles, 1024);
            finishAttempt(1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
